// File: rtl/bcd_round_engine_if.sv
// ----------------------------------------------------------------------------
// bcd_round_engine_if
// Handshake bundle between a BCD producer, the rounding engine and the
// downstream formatter.
//   in_valid/in_ready   : input word handshake
//   in_bcd              : packed BCD word, most significant digit in the MSBs
//   rnd_mode            : rounding mode for the offered word
//   out_valid/out_ready : result handshake
//   out_bcd             : rounded kept digits
//   out_inc/out_ovf/out_err : result flags
// Modports: master = producer/consumer side, slave = engine side.
// ----------------------------------------------------------------------------
interface bcd_round_engine_if #(
   parameter int DIGITS = 6,
   parameter int DROP   = 1
);
   localparam int KEEP = DIGITS - DROP;

   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   in_bcd;
   logic [1:0]            rnd_mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*KEEP-1:0]     out_bcd;
   logic                  out_inc;
   logic                  out_ovf;
   logic                  out_err;

   modport master (
      output in_valid, in_bcd, rnd_mode, out_ready,
      input  in_ready, out_valid, out_bcd, out_inc, out_ovf, out_err
   );

   modport slave (
      input  in_valid, in_bcd, rnd_mode, out_ready,
      output in_ready, out_valid, out_bcd, out_inc, out_ovf, out_err
   );
endinterface

// File: rtl/bcd_round_engine.sv
// ----------------------------------------------------------------------------
// bcd_round_engine
// Drops the DROP low-order digits of a DIGITS-digit packed BCD word and rounds
// the remaining KEEP digits according to a per-word rounding mode. The +1 is
// rippled serially, one kept digit per cycle, stopping at the first non-nine.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, aborts any word in flight
//   bus  : bcd_round_engine_if.slave (input word, mode, result and flags)
//
// Timing: accept edge T, decision at T+1, P ripple cycles, result registered
// one edge later, so out_valid rises 2+P edges after the accept edge.
// ----------------------------------------------------------------------------
module bcd_round_engine #(
   parameter int DIGITS   = 6,
   parameter int DROP     = 1,
   parameter int SATURATE = 0
) (
   input logic               clk,
   input logic               rst,
   bcd_round_engine_if.slave bus
);

   localparam int KEEP  = DIGITS - DROP;
   localparam int KW    = 4 * KEEP;
   localparam int DW    = 4 * DROP;
   localparam int WW    = 4 * DIGITS;
   localparam int IDX_W = (KEEP > 1) ? $clog2(KEEP) : 1;

   // Half of one kept LSB expressed in the dropped field: 5 then DROP-1 zeros.
   localparam logic [DW-1:0]    HALF_C   = DW'(32'd5) << (4 * (DROP - 1));
   localparam logic [IDX_W-1:0] K_LAST_C = IDX_W'(KEEP - 1);
   // Kept-field value written on overflow.
   localparam logic [KW-1:0]    OVF_FILL_C = (SATURATE != 0) ? {KEEP{4'h9}} : {KW{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECIDE = 2'd1,
      ST_PROP   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // --------------------------------------------------------------------
   // Helpers
   // --------------------------------------------------------------------

   // Flags a word containing any nibble outside 0..9.
   function automatic logic has_bad_digit(input logic [WW-1:0] word);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         bad = bad | (word[4*i +: 4] > 4'd9);
      end
      return bad;
   endfunction

   // Rounding decision. For valid BCD, unsigned compare of the raw dropped
   // bits orders the same way as the decimal value, so no conversion needed.
   function automatic logic want_increment(input logic [1:0]    mode,
                                           input logic [DW-1:0] dropped,
                                           input logic          kept_lsb_odd);
      logic up;
      case (mode)
         2'd0:    up = 1'b0;
         2'd1:    up = (dropped >= HALF_C);
         2'd2:    up = (dropped > HALF_C) || ((dropped == HALF_C) && kept_lsb_odd);
         2'd3:    up = (dropped != {DW{1'b0}});
         default: up = 1'b0;
      endcase
      return up;
   endfunction

   // --------------------------------------------------------------------
   // State and storage
   // --------------------------------------------------------------------
   state_t            state_r;
   state_t            state_nx_s;
   logic [KW-1:0]     kept_r;
   logic [DW-1:0]     drop_r;
   logic [1:0]        mode_r;
   logic [IDX_W-1:0]  idx_r;
   logic              inc_r;
   logic              ovf_r;
   logic              err_r;

   logic              out_valid_r;
   logic [KW-1:0]     out_bcd_r;
   logic              out_inc_r;
   logic              out_ovf_r;
   logic              out_err_r;

   logic              in_ready_s;
   logic              accept_s;
   logic              out_fire_s;
   logic              dec_err_s;
   logic              dec_inc_s;
   logic [3:0]        prop_digit_s;
   logic              prop_is9_s;
   logic              prop_last_s;

   // in_ready must read 0 while rst is held even though state sits in IDLE.
   assign in_ready_s   = (state_r == ST_IDLE) && !rst;
   assign accept_s     = bus.in_valid && in_ready_s;
   assign out_fire_s   = out_valid_r && bus.out_ready;

   assign dec_err_s    = has_bad_digit({kept_r, drop_r});
   assign dec_inc_s    = want_increment(mode_r, drop_r, kept_r[0]);

   assign prop_digit_s = kept_r[{idx_r, 2'b00} +: 4];
   assign prop_is9_s   = (prop_digit_s == 4'd9);
   assign prop_last_s  = (idx_r == K_LAST_C);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nx_s = ST_DECIDE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_DECIDE: begin
            if (dec_err_s || !dec_inc_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_PROP;
            end
         end
         ST_PROP: begin
            // Ripple stops at the first non-nine or after the top kept digit.
            if (!prop_is9_s || prop_last_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_PROP;
            end
         end
         ST_DONE: begin
            if (out_fire_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Working datapath: capture, decision flags and the serial carry ripple.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kept_r <= {KW{1'b0}};
         drop_r <= {DW{1'b0}};
         mode_r <= 2'd0;
         idx_r  <= {IDX_W{1'b0}};
         inc_r  <= 1'b0;
         ovf_r  <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  kept_r <= bus.in_bcd[WW-1:DW];
                  drop_r <= bus.in_bcd[DW-1:0];
                  mode_r <= bus.rnd_mode;
               end
            end
            ST_DECIDE: begin
               idx_r <= {IDX_W{1'b0}};
               err_r <= dec_err_s;
               inc_r <= dec_inc_s && !dec_err_s;
               ovf_r <= 1'b0;
            end
            ST_PROP: begin
               if (prop_is9_s) begin
                  if (prop_last_s) begin
                     kept_r <= OVF_FILL_C;
                     ovf_r  <= 1'b1;
                  end else begin
                     kept_r[{idx_r, 2'b00} +: 4] <= 4'd0;
                     idx_r <= idx_r + IDX_W'(1);
                  end
               end else begin
                  kept_r[{idx_r, 2'b00} +: 4] <= prop_digit_s + 4'd1;
               end
            end
            ST_DONE: begin
               kept_r <= kept_r;
            end
            default: begin
               kept_r <= kept_r;
            end
         endcase
      end
   end

   // Result registers: loaded on the first DONE cycle, held until handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_bcd_r   <= {KW{1'b0}};
         out_inc_r   <= 1'b0;
         out_ovf_r   <= 1'b0;
         out_err_r   <= 1'b0;
      end else if (state_r == ST_DONE) begin
         if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            out_bcd_r   <= kept_r;
            out_inc_r   <= inc_r;
            out_ovf_r   <= ovf_r;
            out_err_r   <= err_r;
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_bcd   = out_bcd_r;
   assign bus.out_inc   = out_inc_r;
   assign bus.out_ovf   = out_ovf_r;
   assign bus.out_err   = out_err_r;

endmodule
